// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with refresh prescaler,
// per-frame input snapshot, leading-zero blanking, PWM dimming and anode dead time.
module seven_seg_scan_driver #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned DIM_BITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   HEX_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    lz_blank,
  input  logic [DIM_BITS-1:0]     brightness,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned HEX_W = 4 * N_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [DIM_BITS-1:0] pwm_cnt;
  logic [HEX_W-1:0]    shadow_hex;
  logic [N_DIGITS-1:0] shadow_dp;
  logic [N_DIGITS-1:0] shadow_en;

  logic                slot_end_c;
  logic                frame_end_c;
  logic                zero_run_c;
  logic [N_DIGITS-1:0] lz_mask_c;
  logic [N_DIGITS-1:0] sel_c;
  logic [3:0]          nibble_c;
  logic                lit_c;

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end_c  = (cnt == CNT_LAST);
  assign frame_end_c = slot_end_c && (idx == IDX_LAST);

  // Digit i>0 is a leading zero when every nibble from i up to the top is zero.
  always_comb begin
    zero_run_c = 1'b1;
    lz_mask_c  = '0;
    for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
      zero_run_c   = zero_run_c && (shadow_hex[4*i +: 4] == 4'h0);
      lz_mask_c[i] = zero_run_c;
    end
  end

  always_comb begin
    sel_c      = '0;
    sel_c[idx] = 1'b1;
    nibble_c   = shadow_hex[{idx, 2'b00} +: 4];
    // cnt == 0 is the dead-time cycle that keeps all anodes off between slots
    lit_c = shadow_en[idx]
         && !(lz_blank && lz_mask_c[idx])
         && (pwm_cnt <= brightness)
         && (cnt != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      shadow_hex <= '0;
      shadow_dp  <= '0;
      shadow_en  <= '0;
      anodes     <= '1;
      segments   <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt     <= slot_end_c ? '0 : cnt + CNT_W'(1);
      pwm_cnt <= pwm_cnt + DIM_BITS'(1);
      if (slot_end_c) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (frame_end_c) begin
        shadow_hex <= HEX_in;
        shadow_dp  <= dp_in;
        shadow_en  <= digit_en;
      end
      frame_tick <= frame_end_c;
      anodes     <= lit_c ? ~sel_c : '1;
      segments   <= hex7seg(nibble_c);
      dp         <= ~shadow_dp[idx];
    end
  end

endmodule
